// File: rtl/lsu_wb_if.sv
// Exec-stage, data-memory bus and writeback signals of the load/store/writeback stage.
// The slave modport is the stage itself; master is whatever drives it (pipeline or bench).
interface lsu_wb_if;
   logic        in_valid;
   logic        in_ready;
   logic        reg_w;
   logic        mem_r;
   logic        mem_w;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [31:0] reg_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault_align;
   logic        bus_err;
   logic        state_dbg;

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
   // in_ready depends only on the FSM state, never on in_valid.
   modport slave (
      input  in_valid, reg_w, mem_r, mem_w, rd, funct3, reg_data, mem_addr, mem_data,
             dmem_rdata, dmem_ack,
      output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_en, wb_rd, wb_data, fault_align, bus_err, state_dbg
   );

   modport master (
      output in_valid, reg_w, mem_r, mem_w, rd, funct3, reg_data, mem_addr, mem_data,
             dmem_rdata, dmem_ack,
      input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_en, wb_rd, wb_data, fault_align, bus_err, state_dbg
   );
endinterface

// File: rtl/lsu_wb.sv
// Load/store unit with writeback: ALU results pass straight to writeback, memory ops
// run one bus transaction at a time with alignment checking and a bus timeout.
module lsu_wb #(
   parameter int TIMEOUT = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   lsu_wb_if.slave  bus
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt;
   logic        r_we, r_is_load, r_wb_ok;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [4:0]  r_rd;
   logic        r_wb_en, r_fault, r_bus_err;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic        w_accept, w_is_mem, w_is_load, w_align_ok, w_legal, w_start;
   logic        w_ack_busy, w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_accept   = bus.in_valid && (r_state == S_IDLE);
   assign w_is_mem   = bus.mem_r || bus.mem_w;
   assign w_is_load  = bus.mem_r && !bus.mem_w;
   assign w_ack_busy = (r_state == S_BUSY) && bus.dmem_ack;
   // An ack in the last allowed cycle beats the timeout.
   assign w_timeout  = (r_state == S_BUSY) && !bus.dmem_ack && (r_cnt == TO_LAST);

   always_comb begin
      w_align_ok = 1'b0;
      case (bus.funct3[1:0])
         2'd0:    w_align_ok = 1'b1;
         2'd1:    w_align_ok = !bus.mem_addr[0];
         2'd2:    w_align_ok = (bus.mem_addr[1:0] == 2'b00);
         default: w_align_ok = 1'b0;
      endcase
   end

   // Unsigned widths (funct3[2]) exist only for byte/halfword loads.
   assign w_legal = w_align_ok && (!bus.funct3[2] || (w_is_load && !bus.funct3[1]));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.mem_data;
      if (bus.mem_w) begin
         case (bus.funct3[1:0])
            2'd0: begin
               w_be    = 4'b0001 << bus.mem_addr[1:0];
               w_wdata = {4{bus.mem_data[7:0]}};
            end
            2'd1: begin
               w_be    = 4'b0011 << bus.mem_addr[1:0];
               w_wdata = {2{bus.mem_data[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = bus.mem_data;
            end
         endcase
      end
   end

   always_comb begin
      w_byte = bus.dmem_rdata[7:0];
      case (r_off)
         2'd0:    w_byte = bus.dmem_rdata[7:0];
         2'd1:    w_byte = bus.dmem_rdata[15:8];
         2'd2:    w_byte = bus.dmem_rdata[23:16];
         default: w_byte = bus.dmem_rdata[31:24];
      endcase
      w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      w_load_data = bus.dmem_rdata;
      case (r_f3)
         3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
         3'd4:    w_load_data = {24'd0, w_byte};
         3'd5:    w_load_data = {16'd0, w_half};
         default: w_load_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_is_mem && w_legal) begin
               w_state_nxt = S_BUSY;
               w_start     = 1'b1;
            end
         end
         S_BUSY: begin
            if (bus.dmem_ack || w_timeout) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= 8'd0;
         r_we      <= 1'b0;
         r_is_load <= 1'b0;
         r_wb_ok   <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_be      <= 4'd0;
         r_f3      <= 3'd0;
         r_off     <= 2'd0;
         r_rd      <= 5'd0;
         r_wb_en   <= 1'b0;
         r_wb_rd   <= 5'd0;
         r_wb_data <= 32'd0;
         r_fault   <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_wb_en   <= 1'b0;
         r_fault   <= 1'b0;
         r_bus_err <= 1'b0;
         if (w_start) begin
            r_cnt     <= 8'd0;
            r_we      <= bus.mem_w;
            r_is_load <= w_is_load;
            r_wb_ok   <= bus.reg_w && (bus.rd != 5'd0);
            r_addr    <= {bus.mem_addr[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_be      <= w_be;
            r_f3      <= bus.funct3;
            r_off     <= bus.mem_addr[1:0];
            r_rd      <= bus.rd;
         end else if ((r_state == S_BUSY) && !bus.dmem_ack) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_accept && !w_is_mem) begin
            r_wb_en   <= bus.reg_w && (bus.rd != 5'd0);
            r_wb_rd   <= bus.rd;
            r_wb_data <= bus.reg_data;
         end
         if (w_accept && w_is_mem && !w_legal) r_fault <= 1'b1;
         if (w_ack_busy && r_is_load) begin
            r_wb_en   <= r_wb_ok;
            r_wb_rd   <= r_rd;
            r_wb_data <= w_load_data;
         end
         if (w_timeout) r_bus_err <= 1'b1;
      end
   end

   // dmem_req comes straight from the state flop so an async reset drops it at once.
   assign bus.in_ready    = (r_state == S_IDLE);
   assign bus.dmem_req    = (r_state == S_BUSY);
   assign bus.dmem_we     = r_we && (r_state == S_BUSY);
   assign bus.dmem_addr   = r_addr;
   assign bus.dmem_be     = r_be;
   assign bus.dmem_wdata  = r_wdata;
   assign bus.wb_en       = r_wb_en;
   assign bus.wb_rd       = r_wb_rd;
   assign bus.wb_data     = r_wb_data;
   assign bus.fault_align = r_fault;
   assign bus.bus_err     = r_bus_err;
   assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: ALU writeback, loads, stores, alignment faults,
// bus timeout and reset during a bus transaction.
module tb_lsu_wb;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   req_cycles;

   lsu_wb_if bus ();

   lsu_wb #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.reg_w    = 1'b0;
      bus.mem_r    = 1'b0;
      bus.mem_w    = 1'b0;
      bus.rd       = 5'd0;
      bus.funct3   = 3'd0;
      bus.reg_data = 32'd0;
      bus.mem_addr = 32'd0;
      bus.mem_data = 32'd0;
   endtask

   // Present one instruction at a negedge; return at the next negedge (after the accept edge).
   task automatic issue(input logic rw, input logic mr, input logic mw, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [31:0] rdat,
                        input logic [31:0] addr, input logic [31:0] wdat);
      bus.in_valid = 1'b1;
      bus.reg_w    = rw;
      bus.mem_r    = mr;
      bus.mem_w    = mw;
      bus.rd       = rd;
      bus.funct3   = f3;
      bus.reg_data = rdat;
      bus.mem_addr = addr;
      bus.mem_data = wdat;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic ack_now(input logic [31:0] rdata);
      bus.dmem_rdata = rdata;
      bus.dmem_ack   = 1'b1;
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      idle_inputs();
      bus.dmem_rdata = 32'd0;
      bus.dmem_ack   = 1'b0;

      // reset state
      #2;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("rst_wb_en", 32'(bus.wb_en), 32'd0);
      check("rst_fault", 32'(bus.fault_align), 32'd0);
      check("rst_bus_err", 32'(bus.bus_err), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ALU ops back to back
      bus.in_valid = 1'b1; bus.reg_w = 1'b1; bus.rd = 5'd5; bus.reg_data = 32'h1234;
      @(negedge clk);
      check("alu1_wb_en", 32'(bus.wb_en), 32'd1);
      check("alu1_wb_rd", 32'(bus.wb_rd), 32'd5);
      check("alu1_wb_data", bus.wb_data, 32'h1234);
      check("alu1_ready", 32'(bus.in_ready), 32'd1);
      issue(1'b1, 1'b0, 1'b0, 5'd7, 3'd0, 32'h55AA, 32'd0, 32'd0);
      check("alu2_wb_en", 32'(bus.wb_en), 32'd1);
      check("alu2_wb_rd", 32'(bus.wb_rd), 32'd7);
      check("alu2_wb_data", bus.wb_data, 32'h55AA);
      issue(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 32'hDEAD, 32'd0, 32'd0);
      check("alu_rd0_wb_en", 32'(bus.wb_en), 32'd0);

      // LB at 0x103, ack in first request cycle -> 2-cycle latency
      issue(1'b1, 1'b1, 1'b0, 5'd3, 3'd0, 32'd0, 32'h103, 32'd0);
      check("lb_req", 32'(bus.dmem_req), 32'd1);
      check("lb_ready", 32'(bus.in_ready), 32'd0);
      check("lb_addr", bus.dmem_addr, 32'h100);
      check("lb_be", 32'(bus.dmem_be), 32'hF);
      check("lb_we", 32'(bus.dmem_we), 32'd0);
      check("lb_wb_early", 32'(bus.wb_en), 32'd0);
      ack_now(32'h80FF_FF7F);
      check("lb_wb_en", 32'(bus.wb_en), 32'd1);
      check("lb_wb_rd", 32'(bus.wb_rd), 32'd3);
      check("lb_wb_data", bus.wb_data, 32'hFFFF_FF80);
      check("lb_req_drop", 32'(bus.dmem_req), 32'd0);
      check("lb_ready_back", 32'(bus.in_ready), 32'd1);

      // LHU at 0x102
      issue(1'b1, 1'b1, 1'b0, 5'd4, 3'd5, 32'd0, 32'h102, 32'd0);
      ack_now(32'h80FF_FF7F);
      check("lhu_wb_data", bus.wb_data, 32'h0000_80FF);
      check("lhu_wb_en", 32'(bus.wb_en), 32'd1);

      // LH at 0x100 sign-extends the low halfword
      issue(1'b1, 1'b1, 1'b0, 5'd4, 3'd1, 32'd0, 32'h100, 32'd0);
      ack_now(32'h1234_8001);
      check("lh_wb_data", bus.wb_data, 32'hFFFF_8001);

      // SH at 0x202
      issue(1'b1, 1'b0, 1'b1, 5'd4, 3'd1, 32'd0, 32'h202, 32'h0000_ABCD);
      check("sh_req", 32'(bus.dmem_req), 32'd1);
      check("sh_addr", bus.dmem_addr, 32'h200);
      check("sh_be", 32'(bus.dmem_be), 32'hC);
      check("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
      check("sh_we", 32'(bus.dmem_we), 32'd1);
      @(negedge clk);
      check("sh_hold_addr", bus.dmem_addr, 32'h200);
      check("sh_hold_req", 32'(bus.dmem_req), 32'd1);
      ack_now(32'hFFFF_FFFF);
      check("sh_no_wb", 32'(bus.wb_en), 32'd0);
      check("sh_req_drop", 32'(bus.dmem_req), 32'd0);

      // SB at 0x201
      issue(1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 32'd0, 32'h201, 32'h1234_5677);
      check("sb_be", 32'(bus.dmem_be), 32'h2);
      check("sb_wdata", bus.dmem_wdata, 32'h7777_7777);
      ack_now(32'd0);

      // LW at 0x101 misaligned
      issue(1'b1, 1'b1, 1'b0, 5'd8, 3'd2, 32'd0, 32'h101, 32'd0);
      check("lw_mis_fault", 32'(bus.fault_align), 32'd1);
      check("lw_mis_req", 32'(bus.dmem_req), 32'd0);
      check("lw_mis_ready", 32'(bus.in_ready), 32'd1);
      check("lw_mis_wb", 32'(bus.wb_en), 32'd0);
      @(negedge clk);
      check("lw_mis_fault_pulse", 32'(bus.fault_align), 32'd0);
      check("lw_mis_req_later", 32'(bus.dmem_req), 32'd0);

      // mem_r and mem_w both set with funct3=4: treated as store, so illegal
      issue(1'b1, 1'b1, 1'b1, 5'd8, 3'd4, 32'd0, 32'h0, 32'd0);
      check("prio_store_fault", 32'(bus.fault_align), 32'd1);
      check("prio_store_req", 32'(bus.dmem_req), 32'd0);

      // ack while idle is ignored
      ack_now(32'h1111_1111);
      check("idle_ack_wb", 32'(bus.wb_en), 32'd0);
      check("idle_ack_req", 32'(bus.dmem_req), 32'd0);

      // timeout with no ack
      issue(1'b1, 1'b1, 1'b0, 5'd6, 3'd2, 32'd0, 32'h300, 32'd0);
      req_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.dmem_req) break;
         req_cycles++;
         check("to_no_early_err", 32'(bus.bus_err), 32'd0);
         @(negedge clk);
      end
      check("to_req_cycles", 32'(req_cycles), 32'd16);
      check("to_bus_err", 32'(bus.bus_err), 32'd1);
      check("to_ready", 32'(bus.in_ready), 32'd1);
      check("to_no_wb", 32'(bus.wb_en), 32'd0);
      @(negedge clk);
      check("to_bus_err_pulse", 32'(bus.bus_err), 32'd0);

      // ack on the 16th request cycle wins over timeout
      issue(1'b1, 1'b1, 1'b0, 5'd6, 3'd2, 32'd0, 32'h304, 32'd0);
      repeat (15) @(negedge clk);
      check("ack16_req", 32'(bus.dmem_req), 32'd1);
      ack_now(32'hCAFE_F00D);
      check("ack16_no_err", 32'(bus.bus_err), 32'd0);
      check("ack16_wb_en", 32'(bus.wb_en), 32'd1);
      check("ack16_wb_data", bus.wb_data, 32'hCAFE_F00D);
      @(negedge clk);
      check("ack16_no_err_after", 32'(bus.bus_err), 32'd0);

      // reset in third BUSY cycle
      issue(1'b1, 1'b1, 1'b0, 5'd9, 3'd2, 32'd0, 32'h400, 32'd0);
      repeat (2) @(negedge clk);
      check("rb_req_before", 32'(bus.dmem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rb_req_async", 32'(bus.dmem_req), 32'd0);
      check("rb_ready_async", 32'(bus.in_ready), 32'd1);
      check("rb_state_async", 32'(bus.state_dbg), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ack_now(32'h5555_5555);
      check("rb_late_ack_wb", 32'(bus.wb_en), 32'd0);
      check("rb_late_ack_req", 32'(bus.dmem_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_wb.md
LSU_WB -- requirements
Module: lsu_wb

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum BUSY cycles without dmem_ack before a bus error; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1  the exec stage presents an instruction result.
REQ-005 in_ready  out  1  the block accepts; transfer occurs on an edge where in_valid && in_ready.
REQ-006 reg_w, mem_r, mem_w  in  1 each  the exec stage's write-register, load and store flags.
REQ-007 rd  in  5  destination register; funct3  in  3  load/store width code.
REQ-008 reg_data, mem_addr, mem_data  in  32 each  ALU result, byte address, store data.
REQ-009 dmem_req, dmem_we  out  1 each  bus request and write strobe.
REQ-010 dmem_addr  out  32  mem_addr with bits [1:0] forced to 0.
REQ-011 dmem_be  out  4  byte enables; dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_rdata  in  32; dmem_ack  in  1  one-cycle completion strobe.
REQ-013 wb_en  out  1; wb_rd  out  5; wb_data  out  32  registered one-cycle writeback.
REQ-014 fault_align, bus_err  out  1 each  registered one-cycle fault pulses.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY, and in_ready SHALL equal (state==IDLE), decoded from state only.
REQ-016 On accept with mem_r=0 and mem_w=0: the next cycle drives wb_en=reg_w&&(rd!=0), wb_rd=rd, wb_data=reg_data; state stays IDLE; throughput is 1 per cycle.
REQ-017 mem_w=1 SHALL take priority over mem_r when both are set, and the access is treated as a store.
REQ-018 Legal access: funct3[1:0]=0 at any address; =1 needs addr[0]=0; =2 needs addr[1:0]=0; loads also allow funct3 4 and 5; any other case is a fault.
REQ-019 On an illegal memory accept: fault_align=1 for the next cycle only, with no bus request, no writeback, and state stays IDLE.
REQ-020 On a legal memory accept: state becomes BUSY with dmem_req=1 from the next cycle.
REQ-021 dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL be registered at accept and held stable until the ack edge or the timeout edge.
REQ-022 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-023 Store data: SB replicates data[7:0] x4; SH replicates data[15:0] x2; SW passes data through.
REQ-024 Loads drive dmem_be=4'b1111 and dmem_we=0.
REQ-025 Load result: select the byte at addr[1:0] or the halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-026 On dmem_ack in BUSY: dmem_req drops the next cycle and state returns to IDLE.
REQ-027 A load with an ack SHALL produce a writeback the next cycle, gated by reg_w&&(rd!=0).
REQ-028 A store with an ack SHALL never produce a writeback.
REQ-029 Minimum accept-to-wb_en latency for a load is 2 cycles, when dmem_ack arrives in the first request cycle.
REQ-030 An 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-031 When the counter reaches TIMEOUT-1 with no ack: at that edge go IDLE, drop dmem_req, pulse bus_err for one cycle, and perform no writeback; dmem_req is therefore high for exactly TIMEOUT cycles.
REQ-032 If ack arrives in the same cycle as the timeout condition, ack SHALL win and no bus_err is raised.
REQ-033 dmem_ack received while in IDLE SHALL be ignored.
REQ-034 wb_en, fault_align and bus_err SHALL never be high in the same cycle, and each is high for exactly one cycle per event.

Reset
REQ-035 With rst_n=0, state SHALL become IDLE at once and all outputs SHALL be 0, except in_ready=1; the counter SHALL be 0.
REQ-036 Reset during BUSY SHALL drop dmem_req without waiting for a clock and abandon the transaction; a late ack after reset is ignored.

Verification
REQ-037 ALU op, reg_w=1, rd=5, reg_data=0x1234 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234; back-to-back ops accepted every cycle.
REQ-038 LB at addr 0x103 with rdata=0x80FF_FF7F -> wb_data=0xFFFF_FF80; LHU at 0x102 with the same rdata -> 0x0000_80FF.
REQ-039 SH at 0x202, data 0xABCD -> dmem_addr=0x200, be=4'b1100, wdata=0xABCD_ABCD, we=1; no wb_en.
REQ-040 LW at 0x101 -> fault_align pulse; dmem_req never asserts; in_ready stays 1.
REQ-041 TIMEOUT=16 with no ack -> dmem_req high 16 cycles, then a bus_err pulse and in_ready=1; ack on cycle 16 -> no bus_err.
REQ-042 rst_n low in the 3rd BUSY cycle -> dmem_req=0 immediately, IDLE; a later ack produces no wb_en.
